// File: rtl/reservoir_sensor_cond_pkg.sv
// ----------------------------------------------------------------------------
// reservoir_pkg
// Shared types and helpers for the reservoir sensor front-end.
//   level_t         : 3-bit float-switch level code, bit 0 is the lowest sensor
//   LVL_*           : the four legal thermometer codes
//   is_legal_level  : true when a level code is one of the legal codes
// ----------------------------------------------------------------------------
package reservoir_pkg;

   typedef logic [2:0] level_t;

   localparam level_t LVL_EMPTY = 3'b000;
   localparam level_t LVL_LOW   = 3'b001;
   localparam level_t LVL_MID   = 3'b011;
   localparam level_t LVL_HIGH  = 3'b111;

   // Water can only cover sensors from the bottom up, so any code with a
   // gap (a higher sensor wet while a lower one is dry) is physically
   // impossible and points at a faulty switch.
   function automatic logic is_legal_level(input level_t lvl);
      return (lvl == LVL_EMPTY) || (lvl == LVL_LOW) ||
             (lvl == LVL_MID)   || (lvl == LVL_HIGH);
   endfunction

endpackage

// File: rtl/reservoir_sensor_cond_debounce.sv
// ----------------------------------------------------------------------------
// sensor_debounce
// One float-switch bit: two-flop synchroniser followed by a debounce counter.
// Ports:
//   clk      in  : clock
//   reset_n  in  : asynchronous active-low reset
//   raw      in  : raw switch bit, asynchronous to clk
//   deb      out : debounced, synchronised bit (registered)
// Parameter:
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed before deb moves
// ----------------------------------------------------------------------------
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic deb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; raw is asynchronous so only sync2 is trusted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // The counter tracks how many consecutive cycles sync2 has disagreed
   // with deb. Any agreement restarts the count, so a glitch shorter than
   // DEBOUNCE_CYCLES never moves deb. The flip happens on the cycle that
   // would have taken the count to DEBOUNCE_CYCLES.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync2 == deb) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         deb <= sync2;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/reservoir_sensor_cond.sv
// ----------------------------------------------------------------------------
// reservoir_sensor_cond
// Conditions the three raw float switches into a clean level code for the
// flow controller, with a sticky fault for persistently illegal codes.
// Ports:
//   clk        in      : clock
//   reset_n    in      : asynchronous active-low reset
//   raw_s      in  [2] : raw float switches, bit 0 lowest, asynchronous
//   fault_clr  in      : synchronous request to clear the sticky fault
//   s          out [2] : conditioned level code (registered)
//   s_chg      out     : one-cycle pulse the cycle after s changes
//   fault      out     : sticky sensor fault (registered)
// Parameters:
//   DEBOUNCE_CYCLES : debounce length per bit (1..255)
//   FAULT_LIMIT     : illegal cycles tolerated before fault sets (1..255)
// ----------------------------------------------------------------------------
module reservoir_sensor_cond
   import reservoir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FAULT_LIMIT     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] raw_s,
   input  logic       fault_clr,
   output logic [2:0] s,
   output logic       s_chg,
   output logic       fault
);

   localparam int IW = $clog2(FAULT_LIMIT + 1);

   level_t        deb;
   logic [IW-1:0] inv_cnt;
   logic          deb_legal;
   logic          fault_set;
   level_t        s_next;

   // Each switch is synchronised and debounced on its own; a multi-bit
   // change can therefore briefly look illegal, which the fault counter
   // tolerates.
   for (genvar i = 0; i < 3; i++) begin : gen_bit
      sensor_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (raw_s[i]),
         .deb     (deb[i])
      );
   end

   // Legality check, fault set condition and the next output code. A
   // latched fault overrides everything and reports an empty reservoir so
   // the flow controller fails towards filling. While deb is illegal but
   // not yet a fault, s holds the last good code.
   always_comb begin
      deb_legal = is_legal_level(deb);
      fault_set = !deb_legal && (inv_cnt == IW'(FAULT_LIMIT - 1));
      s_next    = s;
      if (fault) begin
         s_next = LVL_EMPTY;
      end else if (deb_legal) begin
         s_next = deb;
      end
   end

   // Consecutive-illegal counter. It saturates so it cannot wrap back into
   // the set condition, and a clear request restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inv_cnt <= '0;
      end else if (fault_clr || deb_legal) begin
         inv_cnt <= '0;
      end else if (inv_cnt != IW'(FAULT_LIMIT)) begin
         inv_cnt <= inv_cnt + IW'(1);
      end
   end

   // Sticky fault. Setting takes priority over a simultaneous clear so a
   // clear issued just as the limit is reached cannot mask a broken sensor.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if (fault_set) begin
         fault <= 1'b1;
      end else if (fault_clr) begin
         fault <= 1'b0;
      end
   end

   // Output register with a change pulse registered alongside it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s     <= LVL_EMPTY;
         s_chg <= 1'b0;
      end else begin
         s     <= s_next;
         s_chg <= (s_next != s);
      end
   end

endmodule

// File: doc/reservoir_sensor_cond.md
# reservoir_sensor_cond

Front-end conditioner for the reservoir flow controller. Takes the three raw float-switch inputs, synchronises and debounces each bit, and checks that the combined level is a legal thermometer code. It presents a clean, stable `s[2:0]` to the level/flow-rate state machine directly downstream. Persistent illegal codes, such as a stuck or broken sensor, raise a sticky fault and force a safe level code.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised bit must differ from its debounced value before the debounced value changes. Legal range is 1..255.
- `FAULT_LIMIT`, default 8: consecutive cycles of an illegal debounced code before `fault` sets. Legal range is 1..255.

Ports:
- `clk`, in, 1: the single clock; all state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `raw_s`, in, 3: raw float switches, asynchronous to `clk`. Bit 0 is the lowest sensor.
- `fault_clr`, in, 1: synchronous request to clear the sticky fault.
- `s`, out, 3: conditioned level code for the flow controller, registered.
- `s_chg`, out, 1: one-cycle pulse in the cycle after `s` takes a new value.
- `fault`, out, 1: sticky sensor fault, registered.

## Operation
- Reset (`reset_n`=0) immediately clears:
  - sync flops, debounced vector `deb`, debounce counters and invalid counter `inv_cnt` to 0;
  - outputs `s`=000, `s_chg`=0, `fault`=0.
- Synchroniser: two flops per bit, `raw_s` → `sync1` → `sync2`.
- Debounce, per bit, with counter width clog2(`DEBOUNCE_CYCLES`+1):
  - If `sync2`==`deb`, the counter clears.
  - If they differ and counter==`DEBOUNCE_CYCLES`-1, `deb` takes `sync2` and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `deb`.
- Legal codes are 000, 001, 011 and 111. All other codes are illegal.
- Invalid counter:
  - `inv_cnt` increments while `deb` is illegal, saturating at `FAULT_LIMIT`.
  - It clears on any legal `deb`.
- Fault:
  - Set condition: `deb` illegal with `inv_cnt`==`FAULT_LIMIT`-1. `fault` sets at that edge.
  - `fault_clr` clears `fault` and `inv_cnt` at the next edge.
  - If the set condition and `fault_clr` occur in the same cycle, set wins.
- Output `s` register, in priority order:
  1. `fault`=1: `s` is forced to 000 (empty reservoir, maximum fill flow downstream).
  2. `deb` legal: `s` takes `deb`.
  3. `deb` illegal and no fault: `s` holds its last value.
- `s_chg` = (`s` next != `s` current), registered alongside `s`.
- Fault forcing `s` to 000 from a non-zero value also pulses `s_chg`.
- Reset asserted mid-debounce or mid-fault discards all pending state. There is no partial completion.

## Timing
- Raw-to-`s` latency for a clean step, with `raw_s` changing before edge k:
  - `sync2` updates at edge k+1;
  - `deb` updates at edge k+1+`DEBOUNCE_CYCLES`;
  - `s` and `s_chg` update at edge k+2+`DEBOUNCE_CYCLES` (k+6 at the default).
- Fault latency: `fault` sets `FAULT_LIMIT` edges after the first edge where `deb` is illegal. `s` is forced to 000 one edge later.
- Bits debounce independently. A multi-bit raw change whose bits settle at different times can present a transient illegal `deb`. `s` holds through it, and no fault occurs if it lasts fewer than `FAULT_LIMIT` cycles.
- No combinational path from any input to any output.

## Structure
- Package `reservoir_pkg` holds:
  - `level_t` (logic [2:0]);
  - the legal-code constants `LVL_EMPTY`=000, `LVL_LOW`=001, `LVL_MID`=011, `LVL_HIGH`=111;
  - function `is_legal_level(level_t)`.
- Sub-module `sensor_debounce`: one bit, containing the 2-flop synchroniser plus the debounce counter. It is parameterised by `DEBOUNCE_CYCLES` and instantiated three times.
- The top level holds the legality check, `inv_cnt`, the fault latch and the output register.

## Test plan
- Reset then idle: `raw_s`=000 → `s`=000, `fault`=0, `s_chg`=0 for 20 cycles.
- Clean step: `raw_s` 000→001 before edge k → `s`=001 and `s_chg`=1 at edge k+6 only; then 001→011→111, each `s` update 6 edges after its `raw_s` change.
- Glitch: `raw_s` bit 1 high for 3 cycles while `s`=001 → `s` stays 001, `s_chg` never pulses.
- Stuck sensor: `raw_s` 101 held → `s` holds 001, `fault`=1 exactly 8 edges after `deb` first shows 101, `s`=000 with an `s_chg` pulse one edge later.
- Fault clear: with `raw_s` back to 011 and `deb`=011, pulse `fault_clr` → `fault`=0 next edge, `s`=011 one edge after. Then pulse `fault_clr` in the same cycle as a set condition → `fault` remains 1.
- Async reset mid-debounce: assert `reset_n`=0 between clock edges with a counter at 2 → `s`=000 and `fault`=0 immediately; after release, the step completes with full latency from the raw change.
